// File: rtl/spi_ss_router.sv
// spi_ss_router
// Registered N-channel SPI router between one SPI master and N_CH slaves.
// The master's SS/SCLK/MOSI are fanned out to the currently selected slave
// and that slave's MISO is returned, all through one register stage.
// The selected channel changes through a valid/ready handshake. A change is
// only accepted while the bus is idle and the post-frame guard interval has
// elapsed, so a slave never sees a truncated frame or a glitching select.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   sel_valid/sel_in  : channel selection request and requested index
//   sel_ready         : router can accept a selection this cycle
//   sel_err           : one-cycle pulse after an out-of-range index is accepted
//   cur_sel           : currently routed channel
//   busy              : frame in progress or guard interval running
//   m_ss_n/m_sclk/m_mosi/m_miso : master side of the SPI bus
//   s_ss_n/s_sclk/s_mosi/s_miso : per-slave SPI buses, one bit per channel
module spi_ss_router #(
    parameter int   N_CH  = 4,
    parameter int   SEL_W = $clog2(N_CH),
    parameter int   GUARD = 2,
    parameter logic CPOL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel_in,
    output logic             sel_ready,
    output logic             sel_err,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    input  logic             m_ss_n,
    input  logic             m_sclk,
    input  logic             m_mosi,
    output logic             m_miso,
    output logic [N_CH-1:0]  s_ss_n,
    output logic [N_CH-1:0]  s_sclk,
    output logic [N_CH-1:0]  s_mosi,
    input  logic [N_CH-1:0]  s_miso
);

    // The counter only ever needs to reach GUARD; one spare bit keeps the
    // width legal when GUARD is 0.
    localparam int CNT_W = $clog2(GUARD + 2);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
    localparam logic [SEL_W:0]   N_CH_C  = (SEL_W + 1)'(N_CH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_GUARD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              xfer;
    logic              sel_ok;
    logic [N_CH-1:0]   ss_nxt;
    logic [N_CH-1:0]   sclk_nxt;
    logic [N_CH-1:0]   mosi_nxt;
    logic              miso_nxt;

    // Frame-tracking state register and guard counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: a frame runs while m_ss_n is low, then the guard
    // counter must see GUARD consecutive idle cycles before returning to
    // IDLE. A new frame during the guard simply resumes ACTIVE on the same
    // channel because cur_sel cannot change outside IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (!m_ss_n) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end
            end
            ST_ACTIVE: begin
                if (m_ss_n) begin
                    if (GUARD == 0) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_GUARD;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_GUARD: begin
                if (!m_ss_n) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end else if (cnt >= GUARD_C) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Ready requires m_ss_n high as well as IDLE, so a request arriving in
    // the same cycle a frame starts stays pending and the frame keeps the
    // old channel.
    assign sel_ready = (state == ST_IDLE) && m_ss_n;
    assign busy      = (state != ST_IDLE);
    assign xfer      = sel_valid && sel_ready;
    assign sel_ok    = ({1'b0, sel_in} < N_CH_C);

    // Selection register and out-of-range error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= xfer && !sel_ok;
            if (xfer && sel_ok) begin
                cur_sel <= sel_in;
            end
        end
    end

    // Routing decode: only the selected channel follows the master, every
    // other channel is held at its idle levels.
    always_comb begin
        ss_nxt   = '1;
        sclk_nxt = {N_CH{CPOL}};
        mosi_nxt = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                ss_nxt[k]   = m_ss_n;
                sclk_nxt[k] = m_sclk;
                mosi_nxt[k] = m_mosi;
            end
        end
        miso_nxt = (busy || !m_ss_n) ? s_miso[cur_sel] : 1'b0;
    end

    // Output register stage. The asynchronous reset releases every slave
    // select immediately, abandoning any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ss_n <= '1;
            s_sclk <= {N_CH{CPOL}};
            s_mosi <= '0;
            m_miso <= 1'b0;
        end else begin
            s_ss_n <= ss_nxt;
            s_sclk <= sclk_nxt;
            s_mosi <= mosi_nxt;
            m_miso <= miso_nxt;
        end
    end

endmodule
